// File: rtl/hscroll_seq.sv
// hscroll_seq -- sequencer for the 8-bit loadable up/down scroll counter in
// the background layer path.
//
// It holds the CPU-written scroll settings and preloads the external counter
// at the start of every horizontal blank. During active display it steps the
// counter once per pixel, and it keeps a cycle-exact mirror of the counter
// value in pos for the layer fetch logic.
//
// Configuration macro: HSCROLL_SEQ_DBUF_EN
//   defined     : the CPU writes shadow registers. These are copied to the
//                 active registers on each vblank rising edge.
//   not defined : the CPU writes the active registers directly.
//
// Parameters:
//   RUN_LEN     pixel steps issued per active line before freezing (1..256)
//
// Ports:
//   clk         system clock
//   Reset_n     synchronous active-low reset
//   cen         pixel enable (single-clk pulse, >=1 low clk between pulses)
//   hblank      horizontal blank, sampled on cen cycles
//   vblank      vertical blank, sampled on cen cycles
//   flip        screen flip: inverts the count direction and the preload value
//   cpu_we      register write strobe
//   cpu_addr    0 = scroll value, 1 = control (bit0 enable, bit1 reverse)
//   cpu_din     write data
//   cnt_cen     counter clock-enable pulse
//   cnt_load_n  counter load, active-low
//   cnt_ent_n   counter enable T, active-low
//   cnt_enp_n   counter enable P, active-low (always equal to cnt_ent_n)
//   cnt_dir     counter direction, 1 = up
//   cnt_p       counter preload value
//   pos         mirror of the counter value
module hscroll_seq #(
    parameter int unsigned RUN_LEN = 256
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       cen,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       flip,
    input  logic       cpu_we,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       cnt_cen,
    output logic       cnt_load_n,
    output logic       cnt_ent_n,
    output logic       cnt_enp_n,
    output logic       cnt_dir,
    output logic [7:0] cnt_p,
    output logic [7:0] pos
);

    localparam logic [8:0] RUN_LEN_C = 9'(RUN_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RUN
    } state_t;

    state_t     state, state_nx;

    logic       hb_q, vb_q;
    logic       hb_rise, hb_fall, vb_rise;
    logic [8:0] step_cnt;
    logic [7:0] act_scroll;
    logic [1:0] act_ctrl;      // [0] enable, [1] reverse
    logic       act_enable, act_reverse;
    logic       do_load, do_step;
    logic       dir_nx;
    logic [7:0] preload;

    assign act_enable  = act_ctrl[0];
    assign act_reverse = act_ctrl[1];

    // Blank edges compare against the previous cen sample, so they are valid
    // only on cen cycles.
    assign hb_rise = cen &  hblank & ~hb_q;
    assign hb_fall = cen & ~hblank &  hb_q;
    assign vb_rise = cen &  vblank & ~vb_q;

    // ------------------------------------------------------------------
    // CPU-side registers
    // ------------------------------------------------------------------
`ifdef HSCROLL_SEQ_DBUF_EN
    logic [7:0] shadow_scroll;
    logic [1:0] shadow_ctrl;

    // The transfer reads the shadow before this clk's write lands, so a
    // same-clk CPU write is deferred to the next frame.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            shadow_scroll <= '0;
            shadow_ctrl   <= '0;
            act_scroll    <= '0;
            act_ctrl      <= '0;
        end else begin
            if (vb_rise) begin
                act_scroll <= shadow_scroll;
                act_ctrl   <= shadow_ctrl;
            end
            if (cpu_we) begin
                if (cpu_addr) shadow_ctrl   <= cpu_din[1:0];
                else          shadow_scroll <= cpu_din;
            end
        end
    end
`else
    // Without double buffering, the vblank edge has no consumer.
    logic unused_vb_rise;
    assign unused_vb_rise = vb_rise;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            act_scroll <= '0;
            act_ctrl   <= '0;
        end else if (cpu_we) begin
            if (cpu_addr) act_ctrl   <= cpu_din[1:0];
            else          act_scroll <= cpu_din;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        do_load  = 1'b0;
        do_step  = 1'b0;
        dir_nx   = ~(act_reverse ^ flip);
        preload  = flip ? ~act_scroll : act_scroll;
        if (cen) begin
            unique case (state)
                S_IDLE: state_nx = S_IDLE;
                S_LOAD: begin
                    do_load  = 1'b1;
                    state_nx = S_WAIT;
                end
                S_WAIT: if (hb_fall) state_nx = S_RUN;
                S_RUN: begin
                    do_step = 1'b1;
                    if (step_cnt == RUN_LEN_C - 9'd1) state_nx = S_WAIT;
                end
                default: state_nx = S_IDLE;
            endcase
            // A new line start overrides everything, including the run limit.
            if (hb_rise) state_nx = S_LOAD;
        end
    end

    // ------------------------------------------------------------------
    // Registered counter controls and position mirror
    // ------------------------------------------------------------------
    // The strobes (cnt_cen, cnt_load_n, enables) are one clk wide and fall
    // back to idle together. cnt_dir and cnt_p change only on cen edges,
    // so they stay stable while cnt_cen is high.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            cnt_cen    <= 1'b0;
            cnt_load_n <= 1'b1;
            cnt_ent_n  <= 1'b1;
            cnt_dir    <= 1'b1;
            cnt_p      <= '0;
            pos        <= '0;
            step_cnt   <= '0;
            hb_q       <= 1'b0;
            vb_q       <= 1'b0;
        end else begin
            cnt_cen    <= do_load | do_step;
            cnt_load_n <= ~do_load;
            cnt_ent_n  <= ~(do_step & act_enable);
            if (cen) begin
                cnt_dir <= dir_nx;
                hb_q    <= hblank;
                vb_q    <= vblank;
            end
            if (do_load) begin
                cnt_p    <= preload;
                pos      <= preload;
                step_cnt <= '0;
            end
            if (do_step) begin
                step_cnt <= step_cnt + 9'd1;
                if (act_enable) pos <= dir_nx ? pos + 8'd1 : pos - 8'd1;
            end
        end
    end

    assign cnt_enp_n = cnt_ent_n;

endmodule

// File: tb/tb_hscroll_seq.sv
// Directed testbench for hscroll_seq (default RUN_LEN = 256).
module tb_hscroll_seq;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       cen = 1'b0;
    logic       hblank = 1'b0;
    logic       vblank = 1'b0;
    logic       flip = 1'b0;
    logic       cpu_we = 1'b0;
    logic       cpu_addr = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic       cnt_cen, cnt_load_n, cnt_ent_n, cnt_enp_n, cnt_dir;
    logic [7:0] cnt_p, pos;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;
    int n_load = 0;

    logic       c_cen, c_load_n, c_ent_n, c_enp_n, c_dir, c_cen_after;
    logic [7:0] c_p, c_pos;

    always #5 clk = ~clk;

    hscroll_seq #(.RUN_LEN(256)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .cen        (cen),
        .hblank     (hblank),
        .vblank     (vblank),
        .flip       (flip),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cnt_cen    (cnt_cen),
        .cnt_load_n (cnt_load_n),
        .cnt_ent_n  (cnt_ent_n),
        .cnt_enp_n  (cnt_enp_n),
        .cnt_dir    (cnt_dir),
        .cnt_p      (cnt_p),
        .pos        (pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel: cen high for one clk, then snapshot the outputs in the clk
    // that follows (the cnt_cen-high clk) and cnt_cen once more a clk later.
    task automatic pix();
        cen = 1'b1;
        @(posedge clk); #1;
        cen = 1'b0;
        c_cen    = cnt_cen;
        c_load_n = cnt_load_n;
        c_ent_n  = cnt_ent_n;
        c_enp_n  = cnt_enp_n;
        c_dir    = cnt_dir;
        c_p      = cnt_p;
        c_pos    = pos;
        n_pulse += int'(cnt_cen);
        n_load  += int'(!cnt_load_n);
        @(posedge clk); #1;
        c_cen_after = cnt_cen;
    endtask

    task automatic cpu_wr(input logic a, input logic [7:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic vpulse();
        vblank = 1'b1; pix();
        vblank = 1'b0; pix();
    endtask

    // hblank rise (load is issued on the following cen), then hblank fall.
    task automatic line_start(input string tag, input logic [7:0] exp_p);
        hblank = 1'b1; pix();
        pix();
        check({tag, "_ld_cen"},   c_cen, 1);
        check({tag, "_ld_load"},  c_load_n, 0);
        check({tag, "_ld_p"},     c_p, exp_p);
        check({tag, "_ld_pos"},   c_pos, exp_p);
        hblank = 1'b0; pix();
        check({tag, "_fall_nocen"}, c_cen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cen",    cnt_cen, 0);
        check("rst_load_n", cnt_load_n, 1);
        check("rst_ent_n",  cnt_ent_n, 1);
        check("rst_enp_n",  cnt_enp_n, 1);
        check("rst_dir",    cnt_dir, 1);
        check("rst_p",      cnt_p, 8'h00);
        check("rst_pos",    pos, 8'h00);
        Reset_n = 1'b1;
        @(posedge clk); #1;

        // 600 pixels with no blanks: nothing happens
        n_pulse = 0; n_load = 0;
        for (int i = 0; i < 600; i++) pix();
        check("idle_pulses", n_pulse, 0);
        check("idle_loads",  n_load, 0);
        check("idle_pos",    pos, 8'h00);

        // Basic line: scroll 0x20, enable, 10 up-steps
        cpu_wr(1'b0, 8'h20);
        cpu_wr(1'b1, 8'h01);
        vpulse();
        line_start("l1", 8'h20);
        check("l1_ld_ent", c_ent_n, 1);
        n_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            pix();
            if (i == 0) begin
                check("l1_s0_cen",   c_cen, 1);
                check("l1_s0_ent",   c_ent_n, 0);
                check("l1_s0_enp",   c_enp_n, 0);
                check("l1_s0_dir",   c_dir, 1);
                check("l1_s0_load",  c_load_n, 1);
                check("l1_s0_pos",   c_pos, 8'h21);
                check("l1_s0_width", c_cen_after, 0);
            end
        end
        check("l1_pulses", n_pulse, 10);
        check("l1_pos",    pos, 8'h2A);

        // Wrap: 0xFE -> 0xFF -> 0x00 -> 0x01
        cpu_wr(1'b0, 8'hFE);
        vpulse();
        line_start("wr", 8'hFE);
        pix(); check("wr_s1", c_pos, 8'hFF);
        pix(); check("wr_s2", c_pos, 8'h00);
        pix(); check("wr_s3", c_pos, 8'h01);

        // Flip: preload inverted, count down
        flip = 1'b1;
        cpu_wr(1'b0, 8'h05);
        cpu_wr(1'b1, 8'h01);
        vpulse();
        line_start("fl", 8'hFA);
        pix();
        check("fl_dir", c_dir, 0);
        check("fl_ent", c_ent_n, 0);
        for (int i = 0; i < 6; i++) pix();
        check("fl_pos", pos, 8'hF3);
        flip = 1'b0;

        // Mid-frame scroll write
        cpu_wr(1'b0, 8'h40);
`ifdef HSCROLL_SEQ_DBUF_EN
        line_start("mf", 8'h05);
`else
        line_start("mf", 8'h40);
`endif
        vpulse();
        line_start("vf", 8'h40);

        // Run limit: 258 pixels give exactly 256 steps
        n_pulse = 0;
        for (int i = 0; i < 258; i++) pix();
        check("lim_pulses", n_pulse, 256);
        check("lim_last",   c_cen, 0);
        check("lim_pos",    pos, 8'h40);
        check("lim_ent",    cnt_ent_n, 1);

        // Reset for one clk during RUN
        line_start("pr", 8'h40);
        for (int i = 0; i < 3; i++) pix();
        check("pr_pos", pos, 8'h43);
        cen = 1'b1; Reset_n = 1'b0;
        @(posedge clk); #1;
        cen = 1'b0; Reset_n = 1'b1;
        check("mr_cen",    cnt_cen, 0);
        check("mr_load_n", cnt_load_n, 1);
        check("mr_ent_n",  cnt_ent_n, 1);
        check("mr_dir",    cnt_dir, 1);
        check("mr_p",      cnt_p, 8'h00);
        check("mr_pos",    pos, 8'h00);
        @(posedge clk); #1;
        check("mr_nopulse", cnt_cen, 0);
        line_start("ar", 8'h00);
        // Control cleared by reset: pulses still issued, enables idle, pos holds
        pix();
        check("ar_cen", c_cen, 1);
        check("ar_ent", c_ent_n, 1);
        check("ar_pos", c_pos, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hscroll_seq.md
# hscroll_seq

Sequencer for the 8-bit loadable up/down scroll counter in the background layer path. It holds CPU-written scroll settings and preloads the counter at the start of every horizontal blank. It then steps the counter once per pixel during active display. Its control outputs drive the counter's cen/load_n/ent_n/enp_n/direction/P pins directly, and it keeps a cycle-exact mirror of the counter value for the layer fetch logic and for verification.

## Interface
Parameters:
- RUN_LEN, 256: pixel steps issued per active line before the counter is frozen (1..256).

Ports:
- clk  in  1  system clock
- Reset_n  in  1  reset; synchronous, active-low
- cen  in  1  pixel enable; single-clk pulse, at least one low clk between pulses
- hblank  in  1  horizontal blank, sampled only on cen cycles
- vblank  in  1  vertical blank, sampled only on cen cycles
- flip  in  1  screen flip; inverts count direction and preload value
- cpu_we  in  1  register write strobe, one clk
- cpu_addr  in  1  0 = scroll value, 1 = control (bit0 enable, bit1 reverse)
- cpu_din  in  8  write data
- cnt_cen  out  1  counter clock-enable pulse
- cnt_load_n  out  1  counter load, active-low
- cnt_ent_n, cnt_enp_n  out  1 each  counter enables, active-low, always equal
- cnt_dir  out  1  1 = up, 0 = down
- cnt_p  out  8  counter preload value
- pos  out  8  mirror of the counter value

## Operation
- Registers: shadow_scroll, shadow_ctrl (CPU side) and act_scroll, act_ctrl (used by the sequencer). All are 0 after reset.
- Frame transfer: on a cen cycle where vblank is 1 and was 0 at the previous cen, the shadow registers are copied to the active registers. If a CPU write lands in the same clk, the transfer takes the pre-write shadow value.
- Edge detection: hblank/vblank edges are detected by comparison with the values sampled at the previous cen.
- States:
  - IDLE → LOAD on hblank rising edge.
  - LOAD (exactly one cen) → WAIT.
  - WAIT → RUN on hblank falling edge.
  - RUN → WAIT after RUN_LEN steps.
  - From any state, hblank rising edge → LOAD; this takes priority over the RUN_LEN limit.
- LOAD:
  - cnt_p = act_scroll, or ~act_scroll when flip = 1.
  - One cnt_cen pulse is issued with cnt_load_n = 0 in the same clk.
  - pos ← cnt_p; the step counter is cleared.
- WAIT: no cnt_cen pulses; enables are 1.
- RUN: each cen produces one cnt_cen pulse.
  - Enables are 0 iff act_ctrl.enable = 1; otherwise they stay 1 and pos holds.
- Direction: cnt_dir = ~(act_ctrl.reverse ^ flip).
- pos arithmetic: modulo 256. Up from 255 gives 0; down from 0 gives 255. pos changes only when the counter would change.
- Step counter: 9 bits; counts cnt_cen pulses issued in RUN, including those issued with enables inactive.

## Timing
- Every output is registered. cnt_cen rises in the clk after the cen pulse and lasts exactly one clk.
- cnt_load_n, cnt_ent_n, cnt_enp_n, cnt_dir and cnt_p are stable throughout the cnt_cen-high clk.
- cnt_load_n is low only during the LOAD pulse clk.
- pos updates in the same clk edge that raises cnt_cen, so it leads the external counter by one clk.
- Reset values:
  - cnt_cen = 0, cnt_load_n = 1, cnt_ent_n = cnt_enp_n = 1, cnt_dir = 1, cnt_p = 0x00, pos = 0x00.
  - State = IDLE; sampled hblank/vblank = 0.
- Reset mid-line: at the next edge the block returns to the reset values, and any pending cnt_cen pulse is dropped. The external counter shares Reset_n, so both clear together.
- A CPU write is visible in the shadow register one clk later.

## Configuration
- HSCROLL_SEQ_DBUF_EN defined: behaviour is the double-buffered scheme above; scroll changes take effect at the first hblank after vblank rising.
- Not defined:
  - The shadow registers are removed and CPU writes go straight to act_scroll/act_ctrl.
  - A new scroll value takes effect at the next LOAD.
  - A control write takes effect at the next cen.

## Test plan
- Reset, then 600 cen pulses with no blanks → cnt_cen stays 0, cnt_load_n stays 1, pos = 0x00.
- Scroll write 0x20, ctrl write 0x01, vblank pulse, hblank high then low, 10 pixels → one load pulse with cnt_p = 0x20, then 10 cnt_cen pulses with enables 0, dir 1; pos ends at 0x2A.
- Same sequence with scroll 0xFE → pos sequence 0xFE, 0xFF, 0x00, 0x01 (wrap).
- flip = 1 with scroll 0x05, ctrl 0x01 → cnt_p = 0xFA, dir 0; after 7 steps pos = 0xF3.
- With DBUF, a scroll write of 0x40 mid-frame → the next hblank still loads the old value; 0x40 is loaded only after a vblank rising edge. Without DBUF → the next hblank loads 0x40.
- Reset_n low for one clk during RUN → outputs at reset values the next clk; the next hblank rising edge loads 0x00.
